mmio_io_responder: RTL and testbench

- Memory-mapped I/O responder on the CPU memory bus, sitting beside the RAM read/write adapter in the lab top.
- Decodes the CPU's mem_cmd/mem_addr for the I/O address window and serves the board peripherals:
  - synchronized switch input
  - LED output register
  - 16-bit down-counting timer with prescaler, auto-reload and sticky expiry flag
- Read data is returned with the same one-cycle latency as the RAM, so the top muxes read_data using io_hit.

---
 rtl/mmio_io_responder.sv | 213 +++++++++++++++++++++
 tb/tb_mmio_io_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_io_responder.sv
// Memory-mapped I/O responder: LED register, synchronized switches and a prescaled 16-bit down-counting timer.
// Define MMIO_IRQ_EN to add the registered irq output and make CTRL bit2 (IRQ_EN) writable.
module mmio_io_responder #(
    parameter int         PRESCALE = 4,
    parameter logic [8:0] BASE     = 9'h100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    output logic        io_hit,
    input  logic [9:0]  SW,
    output logic [9:0]  LEDR
`ifdef MMIO_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int              PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [8:0]      WIN_SIZE   = 9'd6;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'b00,
        CMD_READ  = 2'b01,
        CMD_WRITE = 2'b10,
        CMD_RSVD  = 2'b11
    } mem_cmd_t;

    typedef enum logic [2:0] {
        OFF_LED    = 3'd0,
        OFF_SW     = 3'd1,
        OFF_CTRL   = 3'd2,
        OFF_LOAD   = 3'd3,
        OFF_COUNT  = 3'd4,
        OFF_STATUS = 3'd5
    } reg_off_t;

    // Architectural state
    logic [9:0]    led_q;
    logic [9:0]    sw_meta;
    logic [9:0]    sw_sync;
    logic          ctrl_en;
    logic          ctrl_auto;
    logic          ctrl_irq_en;
    logic [15:0]   load_q;
    logic [15:0]   count_q;
    logic          exp_q;
    logic [PW-1:0] presc_q;

    // Next-state values
    logic          ctrl_en_d;
    logic          ctrl_auto_d;
    logic          ctrl_irq_en_d;
    logic [15:0]   load_d;
    logic [15:0]   count_d;
    logic          exp_d;
    logic [PW-1:0] presc_d;
    logic [9:0]    led_d;

    // Address decode
    mem_cmd_t      cmd;
    logic [8:0]    addr_off;
    logic          in_window;
    reg_off_t      reg_sel;
    logic          rd_req;
    logic          wr_req;
    logic          wr_led;
    logic          wr_ctrl;
    logic          wr_load;
    logic          wr_status;
    logic [15:0]   rd_mux;

    // Timer events
    logic          tick;
    logic          count_zero;
    logic          expire;

    assign cmd       = mem_cmd_t'(mem_cmd);
    assign addr_off  = mem_addr - BASE;
    assign in_window = (mem_addr >= BASE) && (addr_off < WIN_SIZE);
    assign reg_sel   = reg_off_t'(addr_off[2:0]);

    assign rd_req    = (cmd == CMD_READ)  && in_window;
    assign wr_req    = (cmd == CMD_WRITE) && in_window;
    assign wr_led    = wr_req && (reg_sel == OFF_LED);
    assign wr_ctrl   = wr_req && (reg_sel == OFF_CTRL);
    assign wr_load   = wr_req && (reg_sel == OFF_LOAD);
    assign wr_status = wr_req && (reg_sel == OFF_STATUS);

    assign tick       = ctrl_en && (presc_q == PRESC_LAST);
    assign count_zero = (count_q == 16'd0);
    assign expire     = tick && count_zero;

    assign LEDR = led_q;

    // Read mux sees pre-edge state, so a COUNT read never reflects a same-edge decrement.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        rd_mux = 16'h0000;
        case (reg_sel)
            OFF_LED:    rd_mux = {6'd0, led_q};
            OFF_SW:     rd_mux = {6'd0, sw_sync};
            OFF_CTRL:   rd_mux = {13'd0, ctrl_irq_en, ctrl_auto, ctrl_en};
            OFF_LOAD:   rd_mux = load_q;
            OFF_COUNT:  rd_mux = count_q;
            OFF_STATUS: rd_mux = {15'd0, exp_q};
            default:    rd_mux = 16'h0000;
        endcase
    end

    // Timer and register next-state; later assignments take priority over earlier ones.
    always_comb begin
        led_d         = led_q;
        ctrl_en_d     = ctrl_en;
        ctrl_auto_d   = ctrl_auto;
        ctrl_irq_en_d = ctrl_irq_en;
        load_d        = load_q;
        count_d       = count_q;
        exp_d         = exp_q;
        presc_d       = presc_q;

        if (ctrl_en) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end

        // A clear loses to an expiry on the same edge, since the set below comes later.
        if (wr_status && write_data[0]) begin
            exp_d = 1'b0;
        end

        if (tick) begin
            if (count_zero) begin
                exp_d = 1'b1;
                if (ctrl_auto) begin
                    count_d = load_q;
                end else begin
                    ctrl_en_d = 1'b0;
                end
            end else begin
                count_d = count_q - 16'd1;
            end
        end

        if (wr_led) begin
            led_d = write_data[9:0];
        end

        if (wr_load) begin
            load_d  = write_data;
            count_d = write_data;
            presc_d = '0;
        end

        if (wr_ctrl) begin
            ctrl_en_d   = write_data[0];
            ctrl_auto_d = write_data[1];
`ifdef MMIO_IRQ_EN
            ctrl_irq_en_d = write_data[2];
`else
            ctrl_irq_en_d = 1'b0;
`endif
            if (!ctrl_en && write_data[0]) begin
                presc_d = '0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q       <= '0;
            sw_meta     <= '0;
            sw_sync     <= '0;
            ctrl_en     <= 1'b0;
            ctrl_auto   <= 1'b0;
            ctrl_irq_en <= 1'b0;
            load_q      <= '0;
            count_q     <= '0;
            exp_q       <= 1'b0;
            presc_q     <= '0;
            read_data   <= '0;
            io_hit      <= 1'b0;
        end else begin
            sw_meta     <= SW;
            sw_sync     <= sw_meta;
            led_q       <= led_d;
            ctrl_en     <= ctrl_en_d;
            ctrl_auto   <= ctrl_auto_d;
            ctrl_irq_en <= ctrl_irq_en_d;
            load_q      <= load_d;
            count_q     <= count_d;
            exp_q       <= exp_d;
            presc_q     <= presc_d;
            io_hit      <= rd_req;
            read_data   <= rd_req ? rd_mux : 16'h0000;
        end
    end

`ifdef MMIO_IRQ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= exp_q & ctrl_irq_en;
        end
    end
`endif

endmodule

// File: tb/tb_mmio_io_responder.sv
// Directed bench for mmio_io_responder; read expectations go through a scoreboard queue.
// Builds with or without MMIO_IRQ_EN.
module tb_mmio_io_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        io_hit;
    logic [9:0]  SW;
    logic [9:0]  LEDR;
`ifdef MMIO_IRQ_EN
    logic        irq;
`endif

    mmio_io_responder #(.PRESCALE(4), .BASE(9'h100)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .read_data  (read_data),
        .io_hit     (io_hit),
        .SW         (SW),
        .LEDR       (LEDR)
`ifdef MMIO_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        hit;
        logic [15:0] data;
    } rd_exp_t;

    rd_exp_t sb[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_cmd(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] data);
        mem_cmd    = cmd;
        mem_addr   = addr;
        write_data = data;
        @(posedge clk);
        #1;
        mem_cmd    = 2'b00;
        write_data = 16'h0000;
    endtask

    task automatic bus_write(input logic [8:0] addr, input logic [15:0] data);
        bus_cmd(2'b10, addr, data);
    endtask

    // Expected response is queued at drive time and retired when the registered response appears.
    task automatic bus_read(input logic [8:0] addr, input logic hit, input logic [15:0] data,
                            input string tag);
        rd_exp_t e;
        rd_exp_t got;
        e.tag  = tag;
        e.hit  = hit;
        e.data = data;
        sb.push_back(e);
        bus_cmd(2'b01, addr, 16'h0000);
        got = sb.pop_front();
        check({got.tag, "_hit"},  {31'd0, io_hit}, {31'd0, got.hit});
        check({got.tag, "_data"}, {16'd0, read_data}, {16'd0, got.data});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        mem_cmd    = 2'b00;
        mem_addr   = '0;
        write_data = '0;
        SW         = '0;
        idle(2);
        reset = 1'b0;

        check("rst_ledr", {22'd0, LEDR}, 32'h0);
        check("rst_hit",  {31'd0, io_hit}, 32'h0);
        check("rst_rdata", {16'd0, read_data}, 32'h0);
`ifdef MMIO_IRQ_EN
        check("rst_irq", {31'd0, irq}, 32'h0);
`endif

        // LED register
        bus_write(9'h100, 16'h02A5);
        check("led_out", {22'd0, LEDR}, 32'h2A5);
        bus_read(9'h100, 1'b1, 16'h02A5, "led_rd");
        idle(1);
        check("hit_drop", {31'd0, io_hit}, 32'h0);
        check("rdata_drop", {16'd0, read_data}, 32'h0);

        // Switch synchronizer and window edges
        SW = 10'h3C1;
        idle(3);
        bus_read(9'h101, 1'b1, 16'h03C1, "sw_rd");
        bus_read(9'h0FF, 1'b0, 16'h0000, "below_win");
        bus_read(9'h106, 1'b0, 16'h0000, "above_win");

        // Ignored writes and reserved command
        bus_write(9'h101, 16'h0000);
        bus_write(9'h104, 16'h1234);
        bus_write(9'h0FF, 16'h0000);
        bus_write(9'h106, 16'h0000);
        check("led_keep", {22'd0, LEDR}, 32'h2A5);
        bus_read(9'h104, 1'b1, 16'h0000, "count_ro");
        bus_cmd(2'b11, 9'h100, 16'h0000);
        check("cmd11_led", {22'd0, LEDR}, 32'h2A5);
        check("cmd11_hit", {31'd0, io_hit}, 32'h0);

        // CTRL upper bits; bit2 only exists with the irq option
        bus_write(9'h102, 16'hFFFC);
`ifdef MMIO_IRQ_EN
        bus_read(9'h102, 1'b1, 16'h0004, "ctrl_bits");
`else
        bus_read(9'h102, 1'b1, 16'h0000, "ctrl_bits");
`endif
        bus_write(9'h102, 16'h0000);

        // One-shot: LOAD=3, EN=1 written at edge Ec
        bus_write(9'h103, 16'd3);
        bus_read(9'h103, 1'b1, 16'd3, "load_rd");
        bus_write(9'h102, 16'h0001);
        idle(11);
        bus_read(9'h104, 1'b1, 16'd1, "os_cnt11");   // samples Ec+12, pre-edge value
        bus_read(9'h104, 1'b1, 16'd0, "os_cnt12");
        bus_read(9'h105, 1'b1, 16'd0, "os_exp_pre");
        idle(2);
        bus_read(9'h105, 1'b1, 16'd1, "os_exp");
        bus_read(9'h102, 1'b1, 16'd0, "os_en_clr");
        bus_write(9'h105, 16'h0000);
        bus_read(9'h105, 1'b1, 16'd1, "st_w0");
        bus_write(9'h105, 16'h0001);
        bus_read(9'h105, 1'b1, 16'd0, "st_w1");

        // Auto-reload: LOAD=2, CTRL=3 written at edge Ec
        bus_write(9'h103, 16'd2);
        bus_write(9'h102, 16'h0003);
        idle(11);
        bus_read(9'h105, 1'b1, 16'd0, "au_exp_pre");
        bus_read(9'h105, 1'b1, 16'd1, "au_exp1");
        bus_read(9'h104, 1'b1, 16'd2, "au_reload1");
        bus_write(9'h105, 16'h0001);
        bus_read(9'h105, 1'b1, 16'd0, "au_clr");
        idle(7);
        bus_write(9'h105, 16'h0001);                 // lands on the expiry edge Ec+24
        bus_read(9'h105, 1'b1, 16'd1, "au_race");
        bus_read(9'h104, 1'b1, 16'd2, "au_reload2");
        bus_read(9'h102, 1'b1, 16'd3, "au_ctrl");

        // Asynchronous reset mid-count
        bus_write(9'h103, 16'd5);
        bus_read(9'h104, 1'b1, 16'd5, "pre_rst_cnt");
        #2;
        reset = 1'b1;
        #1;
        check("arst_ledr", {22'd0, LEDR}, 32'h0);
        check("arst_hit", {31'd0, io_hit}, 32'h0);
        check("arst_rdata", {16'd0, read_data}, 32'h0);
        idle(1);
        reset = 1'b0;
        bus_read(9'h100, 1'b1, 16'd0, "arst_led_rd");
        bus_read(9'h102, 1'b1, 16'd0, "arst_ctrl_rd");
        bus_read(9'h103, 1'b1, 16'd0, "arst_load_rd");
        bus_read(9'h104, 1'b1, 16'd0, "arst_cnt_rd");
        bus_read(9'h105, 1'b1, 16'd0, "arst_st_rd");

        // LOAD=0 with AUTO: expiry on every tick
        bus_write(9'h103, 16'd0);
        bus_write(9'h102, 16'h0003);
        idle(3);
        bus_read(9'h105, 1'b1, 16'd0, "z_exp_pre");
        bus_read(9'h105, 1'b1, 16'd1, "z_exp1");
        bus_write(9'h105, 16'h0001);
        bus_read(9'h105, 1'b1, 16'd0, "z_clr");
        bus_read(9'h105, 1'b1, 16'd0, "z_pre2");
        bus_read(9'h105, 1'b1, 16'd1, "z_exp2");
        bus_write(9'h102, 16'h0000);
        bus_write(9'h105, 16'h0001);

`ifdef MMIO_IRQ_EN
        // irq follows EXP & IRQ_EN one cycle later
        bus_write(9'h103, 16'd0);
        bus_write(9'h102, 16'h0005);
        check("irq_0", {31'd0, irq}, 32'h0);
        idle(4);
        check("irq_exp_edge", {31'd0, irq}, 32'h0);
        idle(1);
        check("irq_set", {31'd0, irq}, 32'h1);
        bus_write(9'h105, 16'h0001);
        check("irq_hold", {31'd0, irq}, 32'h1);
        idle(1);
        check("irq_drop", {31'd0, irq}, 32'h0);
        bus_read(9'h102, 1'b1, 16'h0004, "irq_ctrl");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
